// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - round-robin sequencer feeding a shared ALU through registered operands
module alu_sequencer #(
   parameter int WIDTH       = 32,
   parameter int OPW         = 4,
   parameter int EXEC_CYCLES = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_src1,
   input  logic [WIDTH-1:0] req0_src2,
   input  logic [OPW-1:0]   req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_src1,
   input  logic [WIDTH-1:0] req1_src2,
   input  logic [OPW-1:0]   req1_op,
   output logic [WIDTH-1:0] alu_src1,
   output logic [WIDTH-1:0] alu_src2,
   output logic [OPW-1:0]   alu_op,
   input  logic [WIDTH-1:0] alu_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_id,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

   state_t     state;
   logic       last_grant;
   logic       grant_id;
   logic [3:0] cnt;
   logic       grant0;
   logic       grant1;

   // On a tie the requester not granted last wins; ready is gated off while reset is held.
   assign grant0 = reset && (state == IDLE) && req0_valid && (!req1_valid || last_grant);
   assign grant1 = reset && (state == IDLE) && req1_valid && (!req0_valid || !last_grant);

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         grant_id   <= 1'b0;
         cnt        <= 4'd0;
         alu_src1   <= '0;
         alu_src2   <= '0;
         alu_op     <= '0;
         rsp_data   <= '0;
         rsp_id     <= 1'b0;
         rsp_valid  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant0 || grant1) begin
                  alu_src1   <= grant1 ? req1_src1 : req0_src1;
                  alu_src2   <= grant1 ? req1_src2 : req0_src2;
                  alu_op     <= grant1 ? req1_op : req0_op;
                  grant_id   <= grant1;
                  last_grant <= grant1;
                  cnt        <= CNT_INIT;
                  busy       <= 1'b1;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               if (cnt == 4'd0) begin
                  rsp_data  <= alu_result;
                  rsp_id    <= grant_id;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - scoreboard bench for alu_sequencer
module tb_alu_sequencer;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_MUL = 4'd2;

   typedef struct {
      logic [31:0] data;
      logic        id;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   exp_t        qa[$];
   exp_t        qb[$];

   logic        a_r0v = 1'b0, a_r1v = 1'b0, a_r0rdy, a_r1rdy;
   logic [31:0] a_r0s1 = '0, a_r0s2 = '0, a_r1s1 = '0, a_r1s2 = '0;
   logic [3:0]  a_r0op = '0, a_r1op = '0, a_op;
   logic [31:0] a_s1, a_s2, a_res, a_data;
   logic        a_rv, a_rr = 1'b1, a_id, a_busy;

   logic        b_r0v = 1'b0, b_r0rdy, b_r1rdy;
   logic [31:0] b_r0s1 = '0, b_r0s2 = '0;
   logic [3:0]  b_r0op = '0, b_op;
   logic [31:0] b_s1, b_s2, b_res, b_data;
   logic        b_rv, b_id, b_busy;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] alu_model(logic [31:0] x, logic [31:0] y, logic [3:0] op);
      case (op)
         4'd0: return x + y;
         4'd1: return x - y;
         4'd2: return x * y;
         default: return 32'd0;
      endcase
   endfunction

   assign a_res = alu_model(a_s1, a_s2, a_op);
   assign b_res = alu_model(b_s1, b_s2, b_op);

   alu_sequencer #(.WIDTH(32), .OPW(4), .EXEC_CYCLES(1)) dut_a (
      .clk(clk), .reset(rst_n),
      .req0_valid(a_r0v), .req0_ready(a_r0rdy), .req0_src1(a_r0s1), .req0_src2(a_r0s2), .req0_op(a_r0op),
      .req1_valid(a_r1v), .req1_ready(a_r1rdy), .req1_src1(a_r1s1), .req1_src2(a_r1s2), .req1_op(a_r1op),
      .alu_src1(a_s1), .alu_src2(a_s2), .alu_op(a_op), .alu_result(a_res),
      .rsp_valid(a_rv), .rsp_ready(a_rr), .rsp_data(a_data), .rsp_id(a_id), .busy(a_busy)
   );

   alu_sequencer #(.WIDTH(32), .OPW(4), .EXEC_CYCLES(4)) dut_b (
      .clk(clk), .reset(rst_n),
      .req0_valid(b_r0v), .req0_ready(b_r0rdy), .req0_src1(b_r0s1), .req0_src2(b_r0s2), .req0_op(b_r0op),
      .req1_valid(1'b0), .req1_ready(b_r1rdy), .req1_src1(32'd0), .req1_src2(32'd0), .req1_op(4'd0),
      .alu_src1(b_s1), .alu_src2(b_s2), .alu_op(b_op), .alu_result(b_res),
      .rsp_valid(b_rv), .rsp_ready(1'b1), .rsp_data(b_data), .rsp_id(b_id), .busy(b_busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic monitor();
      logic        pv = 1'b0, pr = 1'b1, pid = 1'b0;
      logic [31:0] pd = '0;
      exp_t        e;
      forever begin
         @(negedge clk);
         chk("ready_exclusive", {31'd0, a_r0rdy & a_r1rdy}, 32'd0);
         if (rst_n && pv && !pr) begin
            chk("hold_valid", {31'd0, a_rv}, 32'd1);
            chk("hold_data", a_data, pd);
            chk("hold_id", {31'd0, a_id}, {31'd0, pid});
         end
         if (a_rv && a_rr) begin
            if (qa.size() == 0) begin
               chk("unexpected_rsp_a", a_data, 32'hFFFF_FFFF);
            end else begin
               e = qa.pop_front();
               chk("rsp_data_a", a_data, e.data);
               chk("rsp_id_a", {31'd0, a_id}, {31'd0, e.id});
               if (e.cyc >= 0) chk("rsp_cycle_a", cyc, e.cyc);
            end
         end
         if (b_rv) begin
            if (qb.size() == 0) begin
               chk("unexpected_rsp_b", b_data, 32'hFFFF_FFFF);
            end else begin
               e = qb.pop_front();
               chk("rsp_data_b", b_data, e.data);
               chk("rsp_id_b", {31'd0, b_id}, {31'd0, e.id});
               chk("rsp_cycle_b", cyc, e.cyc);
            end
         end
         pv = a_rv; pr = a_rr; pd = a_data; pid = a_id;
      end
   endtask

   // mode: 0 = no response expected, 1 = response at accept+2, 2 = response at unknown cycle
   task automatic issue(input bit id, input logic [31:0] s1, input logic [31:0] s2, input logic [3:0] op,
                        input logic [31:0] expd, input int mode, output int waits, output int acc);
      bit   got = 1'b0;
      exp_t e;
      if (id) begin a_r1s1 = s1; a_r1s2 = s2; a_r1op = op; a_r1v = 1'b1; end
      else    begin a_r0s1 = s1; a_r0s2 = s2; a_r0op = op; a_r0v = 1'b1; end
      waits = 0;
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clk);
         if (id ? a_r1rdy : a_r0rdy) got = 1'b1;
         else waits++;
      end
      chk("accept", {31'd0, got}, 32'd1);
      acc = cyc;
      if (got && mode != 0) begin
         e.data = expd; e.id = id; e.cyc = (mode == 1) ? cyc + 2 : -1;
         qa.push_back(e);
      end
      @(posedge clk); #1;
   endtask

   int   w, acc1, acc2, hs;
   bit   seen;
   logic [31:0] rr_data [4] = '{32'd2, 32'd4, 32'd2, 32'd4};
   logic        rr_id   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
   exp_t e;

   initial begin
      fork monitor(); join_none

      // reset state, with a requester already valid
      a_r0v = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_ready0", {31'd0, a_r0rdy}, 32'd0);
      chk("reset_rsp_valid", {31'd0, a_rv}, 32'd0);
      chk("reset_busy", {31'd0, a_busy}, 32'd0);
      chk("reset_alu_src1", a_s1, 32'd0);
      chk("reset_rsp_data", a_data, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1; a_r0v = 1'b0;
      @(posedge clk); #1;

      // single-operation latency
      issue(1'b0, 32'd10, 32'd5, OP_ADD, 32'd15, 1, w, acc1);
      a_r0v = 1'b0;
      chk("lat_accept_cycle0", w, 32'd0);
      @(negedge clk);
      chk("lat_alu_src1", a_s1, 32'd10);
      chk("lat_busy", {31'd0, a_busy}, 32'd1);
      repeat (3) @(posedge clk); #1;

      // sequential operations from requester 1
      issue(1'b1, 32'd20, 32'd10, OP_SUB, 32'd10, 1, w, acc1);
      issue(1'b1, 32'd5, 32'd6, OP_MUL, 32'd30, 1, w, acc2);
      a_r1v = 1'b0;
      chk("seq_spacing", acc2 - acc1, 32'd3);
      repeat (4) @(posedge clk); #1;

      // round-robin with both requesters continuously valid
      a_r0s1 = 32'd1; a_r0s2 = 32'd1; a_r0op = OP_ADD; a_r0v = 1'b1;
      a_r1s1 = 32'd2; a_r1s2 = 32'd2; a_r1op = OP_ADD; a_r1v = 1'b1;
      for (int k = 0; k < 4; k++) begin
         seen = 1'b0;
         for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (a_r0rdy || a_r1rdy) seen = 1'b1;
         end
         chk("rr_grant_seen", {31'd0, seen}, 32'd1);
         chk("rr_grant_id", {31'd0, a_r1rdy}, {31'd0, rr_id[k]});
         e.data = rr_data[k]; e.id = rr_id[k]; e.cyc = cyc + 2;
         qa.push_back(e);
         @(posedge clk); #1;
      end
      a_r0v = 1'b0; a_r1v = 1'b0;
      repeat (4) @(posedge clk); #1;

      // response backpressure
      a_rr = 1'b0;
      issue(1'b0, 32'd9, 32'd9, OP_ADD, 32'd18, 2, w, acc1);
      a_r0s1 = 32'd9; a_r0s2 = 32'd4; a_r0op = OP_SUB;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = a_rv;
      end
      chk("bp_rsp_valid", {31'd0, seen}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_ready0_low", {31'd0, a_r0rdy}, 32'd0);
      end
      @(posedge clk); #1;
      a_rr = 1'b1;
      @(negedge clk);
      hs = cyc;
      chk("bp_ready0_at_hs", {31'd0, a_r0rdy}, 32'd0);
      @(negedge clk);
      chk("bp_next_accept", {31'd0, a_r0rdy}, 32'd1);
      chk("bp_next_cycle", cyc - hs, 32'd1);
      e.data = 32'd5; e.id = 1'b0; e.cyc = cyc + 2;
      qa.push_back(e);
      @(posedge clk); #1;
      a_r0v = 1'b0;
      repeat (4) @(posedge clk); #1;

      // multi-cycle execution on the EXEC_CYCLES=4 instance
      b_r0s1 = 32'd7; b_r0s2 = 32'd8; b_r0op = OP_ADD; b_r0v = 1'b1;
      @(negedge clk);
      chk("mc_accept", {31'd0, b_r0rdy}, 32'd1);
      e.data = 32'd15; e.id = 1'b0; e.cyc = cyc + 5;
      qb.push_back(e);
      @(posedge clk); #1;
      b_r0v = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         chk("mc_busy", {31'd0, b_busy}, 32'd1);
      end
      @(negedge clk);
      chk("mc_idle_after", {31'd0, b_busy}, 32'd0);
      @(posedge clk); #1;

      // reset asserted mid-operation
      issue(1'b0, 32'd50, 32'd20, OP_SUB, 32'd0, 0, w, acc1);
      a_r0v = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_rsp_valid", {31'd0, a_rv}, 32'd0);
      chk("rst_busy", {31'd0, a_busy}, 32'd0);
      chk("rst_alu_op", {28'd0, a_op}, 32'd0);
      repeat (2) @(posedge clk); #1;
      rst_n = 1'b1;
      issue(1'b0, 32'd3, 32'd4, OP_ADD, 32'd7, 1, w, acc1);
      a_r0v = 1'b0;
      chk("rst_first_accept", w, 32'd0);

      for (int i = 0; i < 50 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("drain_a", qa.size(), 32'd0);
      chk("drain_b", qb.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
